// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - request/response and register-file port bundle for regfile_access_ctrl
`timescale 1ns/1ps
interface regfile_access_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_src_a;
    logic [ADDR_W-1:0] req_src_b;
    logic              req_wr_en;
    logic [ADDR_W-1:0] req_dst;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;
    logic [ADDR_W-1:0] rf_address;
    logic              rf_write;
    logic [DATA_W-1:0] rf_in;
    logic [DATA_W-1:0] rf_out;

    // Controller side: accepts requests, returns operands, drives the file port.
    modport slave (
        input  req_valid, req_src_a, req_src_b, req_wr_en, req_dst, req_wdata,
        input  rsp_ready, rf_out,
        output req_ready, rsp_valid, rsp_a, rsp_b, rf_address, rf_write, rf_in
    );

    // Requester side, together with the register file it talks to.
    modport master (
        output req_valid, req_src_a, req_src_b, req_wr_en, req_dst, req_wdata,
        output rsp_ready, rf_out,
        input  req_ready, rsp_valid, rsp_a, rsp_b, rf_address, rf_write, rf_in
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - sequenced read A / read B / write-back access to a single-port register file (optional RF_SYNC_READ_EN)
`timescale 1ns/1ps
module regfile_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    regfile_access_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
    logic              read_done;

`ifdef RF_SYNC_READ_EN
    // Registered-read file: each read state holds its address for two cycles,
    // phase_q marks the second cycle, when rf_out reflects the held address.
    logic phase_q, phase_d;

    // Toggle the phase while in a read state, clear it everywhere else.
    always_comb begin
        phase_d = 1'b0;
        if (state_q == S_RD_A || state_q == S_RD_B) begin
            phase_d = ~phase_q;
        end
    end

    // Phase register, cleared by reset so a new read always starts at phase 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign read_done = phase_q;
`else
    assign read_done = 1'b1;
`endif

    // State and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            wr_en_q <= 1'b0;
            dst_q   <= '0;
            wdata_q <= '0;
            rsp_a_q <= '0;
            rsp_b_q <= '0;
        end else begin
            state_q <= state_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            wr_en_q <= wr_en_d;
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            rsp_a_q <= rsp_a_d;
            rsp_b_q <= rsp_b_d;
        end
    end

    // Next state: fixed order read A, read B, optional write, then hold response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = S_RD_A;
            S_RD_A:  if (read_done)     state_d = S_RD_B;
            S_RD_B:  if (read_done)     state_d = wr_en_q ? S_WR : S_RESP;
            S_WR:                       state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Request latch on accept and operand capture at the end of each read.
    // Reads happen before the write, so a src equal to dst returns the old value.
    always_comb begin
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        wr_en_d = wr_en_q;
        dst_d   = dst_q;
        wdata_d = wdata_q;
        rsp_a_d = rsp_a_q;
        rsp_b_d = rsp_b_q;
        if (state_q == S_IDLE && bus.req_valid) begin
            src_a_d = bus.req_src_a;
            src_b_d = bus.req_src_b;
            wr_en_d = bus.req_wr_en;
            dst_d   = bus.req_dst;
            wdata_d = bus.req_wdata;
        end
        if (state_q == S_RD_A && read_done) begin
            rsp_a_d = bus.rf_out;
        end
        if (state_q == S_RD_B && read_done) begin
            rsp_b_d = bus.rf_out;
        end
    end

    // Outputs decoded from the registered state; the write strobe is also
    // gated by reset_n so the file is never written while reset is held.
    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.rsp_valid  = (state_q == S_RESP);
        bus.rf_address = '0;
        bus.rf_in      = '0;
        bus.rf_write   = 1'b0;
        case (state_q)
            S_RD_A: bus.rf_address = src_a_q;
            S_RD_B: bus.rf_address = src_b_q;
            S_WR: begin
                bus.rf_address = dst_q;
                bus.rf_in      = wdata_q;
                bus.rf_write   = reset_n;
            end
            default: ;
        endcase
    end

    assign bus.rsp_a = rsp_a_q;
    assign bus.rsp_b = rsp_b_q;
endmodule
